mu0_mem_responder: RTL

MU0_MEM_RESPONDER -- requirements
Module: mu0_mem_responder

---
 rtl/mu0_mem_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mu0_mem_responder.sv
// MU0 memory responder: 4K x 16 word store with a wait-state FSM
// and one memory-mapped output register.
module mu0_mem_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [11:0] IO_ADDR     = 12'hFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] Address,
  input  logic [15:0] Wdata,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] Rdata,
  output logic        Ready,
  output logic        Err,
  output logic [15:0] IoOut
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] io_q, io_d;

  logic [15:0] mem [4096];
  logic        is_io;
  logic        mem_we;
  logic [15:0] rd_val;

  assign is_io  = (addr_q == IO_ADDR);
  assign rd_val = is_io ? io_q : mem[addr_q];
  assign mem_we = (state_q == DONE) && wr_q && !is_io && !Reset;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      io_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      io_q    <= io_d;
    end
  end

  // Storage has no reset; writes are gated off while Reset is high.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    io_d    = io_q;
    unique case (state_q)
      IDLE: begin
        if (Rd && Wr) begin
          err_d = 1'b1;
        end else if (Rd || Wr) begin
          addr_d  = Address;
          wdata_d = Wdata;
          wr_d    = Wr;
          cnt_d   = WS;
          state_d = (WS != 4'd0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (wr_q && is_io) begin
          io_d = wdata_q;
        end
        if (!wr_q) begin
          rdata_d = rd_val;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data is driven straight from storage during DONE, then held.
  always_comb begin
    Ready = (state_q == DONE);
    Err   = err_q;
    IoOut = io_q;
    Rdata = rdata_q;
    if ((state_q == DONE) && !wr_q) begin
      Rdata = rd_val;
    end
  end

endmodule
